// File: rtl/range_union_counter.sv
// Range union counter: insertion-sorts inclusive ranges, then merges them to count covered IDs.
// Optional mergedCount port enabled with `define RANGE_UNION_MERGED_COUNT_EN.
module range_union_counter #(
   parameter  int WIDTH  = 64,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] inLow,
   input  logic [WIDTH-1:0] inHigh,
   input  logic             inLast,
   output logic [WIDTH:0]   freshCount,
   output logic             done,
   output logic             countValid,
   output logic             overflow
`ifdef RANGE_UNION_MERGED_COUNT_EN
   ,
   output logic [ADDR_W:0]  mergedCount
`endif
);

   localparam int IW = (ADDR_W > 0) ? ADDR_W : 1;
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      LOAD,
      SHIFT,
      MERGE,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] lo_mem [DEPTH];
   logic [WIDTH-1:0] hi_mem [DEPTH];

   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    ptr_q;
   logic [WIDTH-1:0] new_lo_q;
   logic [WIDTH-1:0] new_hi_q;
   logic             last_q;

   logic [CW-1:0]    idx_q;
   logic [WIDTH-1:0] cur_lo_q;
   logic [WIDTH-1:0] cur_hi_q;
   logic             run_q;
   logic [WIDTH:0]   acc_q;
   logic             done_q;
   logic             ovf_q;

`ifdef RANGE_UNION_MERGED_COUNT_EN
   logic [CW-1:0]    runs_q;
`endif

   logic             accept;
   logic             full;
   logic [WIDTH-1:0] beat_lo;
   logic [WIDTH-1:0] beat_hi;
   logic [IW-1:0]    ptr_i;
   logic [IW-1:0]    prev_i;
   logic             shift_go;
   logic [IW-1:0]    idx_i;
   logic [WIDTH-1:0] e_lo;
   logic [WIDTH-1:0] e_hi;
   logic             scan_end;
   logic [WIDTH:0]   cur_hi_p1;
   logic             touch;
   logic [WIDTH:0]   run_len;
   logic [WIDTH-1:0] hi_max;

   assign accept   = inValid && (state_q == LOAD);
   assign full     = (cnt_q == FULL);
   assign beat_lo  = (inLow > inHigh) ? inHigh : inLow;
   assign beat_hi  = (inLow > inHigh) ? inLow : inHigh;

   assign ptr_i    = ptr_q[IW-1:0];
   assign prev_i   = ptr_i - IW'(1);
   assign shift_go = (ptr_q != '0) && (lo_mem[prev_i] > new_lo_q);

   assign idx_i    = idx_q[IW-1:0];
   assign e_lo     = lo_mem[idx_i];
   assign e_hi     = hi_mem[idx_i];
   assign scan_end = (idx_q == cnt_q);

   // Widened so a run ending at the top of the space still touches nothing past it.
   assign cur_hi_p1 = {1'b0, cur_hi_q} + (WIDTH+1)'(1);
   assign touch     = ({1'b0, e_lo} <= cur_hi_p1);
   assign run_len   = {1'b0, cur_hi_q} - {1'b0, cur_lo_q}
                    + (WIDTH+1)'(1);
   assign hi_max    = (e_hi > cur_hi_q) ? e_hi : cur_hi_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and state-qualified outputs.
   always_comb begin
      state_d    = state_q;
      inReady    = 1'b0;
      countValid = 1'b0;
      freshCount = '0;
      unique case (state_q)
         LOAD: begin
            inReady = 1'b1;
            if (inValid) begin
               if (full) begin
                  state_d = inLast ? MERGE : LOAD;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (!shift_go) begin
               state_d = last_q ? MERGE : LOAD;
            end
         end
         MERGE: begin
            if (scan_end) begin
               state_d = DONE;
            end
         end
         DONE: begin
            countValid = 1'b1;
            freshCount = acc_q;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   assign done     = done_q;
   assign overflow = ovf_q;

`ifdef RANGE_UNION_MERGED_COUNT_EN
   assign mergedCount = countValid ? runs_q : '0;
`endif

   // Table storage: ripple larger entries up, then drop the new one in the hole.
   always_ff @(posedge clk) begin
      if (!rst && state_q == SHIFT) begin
         if (shift_go) begin
            lo_mem[ptr_i] <= lo_mem[prev_i];
            hi_mem[ptr_i] <= hi_mem[prev_i];
         end else begin
            lo_mem[ptr_i] <= new_lo_q;
            hi_mem[ptr_i] <= new_hi_q;
         end
      end
   end

   // Insertion bookkeeping and the merge-scan accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         ptr_q    <= '0;
         new_lo_q <= '0;
         new_hi_q <= '0;
         last_q   <= 1'b0;
         idx_q    <= '0;
         cur_lo_q <= '0;
         cur_hi_q <= '0;
         run_q    <= 1'b0;
         acc_q    <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef RANGE_UNION_MERGED_COUNT_EN
         runs_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            LOAD: begin
               if (accept) begin
                  idx_q <= '0;
                  run_q <= 1'b0;
                  acc_q <= '0;
`ifdef RANGE_UNION_MERGED_COUNT_EN
                  runs_q <= '0;
`endif
                  if (full) begin
                     ovf_q <= 1'b1;
                  end else begin
                     new_lo_q <= beat_lo;
                     new_hi_q <= beat_hi;
                     last_q   <= inLast;
                     ptr_q    <= cnt_q;
                  end
               end
            end
            SHIFT: begin
               if (shift_go) begin
                  ptr_q <= ptr_q - CW'(1);
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            MERGE: begin
               if (!scan_end) begin
                  idx_q <= idx_q + CW'(1);
                  if (!run_q || !touch) begin
                     if (run_q) begin
                        acc_q <= acc_q + run_len;
                     end
                     cur_lo_q <= e_lo;
                     cur_hi_q <= e_hi;
                     run_q    <= 1'b1;
`ifdef RANGE_UNION_MERGED_COUNT_EN
                     runs_q   <= runs_q + CW'(1);
`endif
                  end else begin
                     cur_hi_q <= hi_max;
                  end
               end else begin
                  if (run_q) begin
                     acc_q <= acc_q + run_len;
                  end
                  done_q <= 1'b1;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/range_union_counter.md
RANGE_UNION_COUNTER -- requirements
Module: range_union_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the bit width of range bounds.
REQ-002 SHALL have parameter DEPTH, default 256, the maximum stored ranges; ADDR_W = clog2(DEPTH) is derived from it.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port inValid  input  1  a range beat is offered.
REQ-006 SHALL have port inReady  output  1  the block can accept a beat this cycle.
REQ-007 SHALL have port inLow  input  WIDTH  inclusive low bound of the beat.
REQ-008 SHALL have port inHigh  input  WIDTH  inclusive high bound of the beat.
REQ-009 SHALL have port inLast  input  1  marks the final beat of the job.
REQ-010 SHALL have port freshCount  output  WIDTH+1  the number of distinct IDs covered by the union of the ranges.
REQ-011 SHALL have port done  output  1  one-cycle pulse when freshCount becomes final.
REQ-012 SHALL have port countValid  output  1  level signal; freshCount is final.
REQ-013 SHALL have port overflow  output  1  sticky flag; a beat was discarded because the table was full.

Function
REQ-014 SHALL implement states LOAD, SHIFT, MERGE, DONE; the block leaves reset in LOAD.
REQ-015 A beat SHALL transfer only on a cycle with inValid && inReady; inReady SHALL be high only in LOAD.
REQ-016 If inLow > inHigh on an accepted beat, the bounds SHALL be swapped before storage.
REQ-017 An accepted beat SHALL be stored by insertion sort, keeping the table ascending by low bound; on equal low bounds the new entry goes after the existing ones.
REQ-018 Insertion transitions: LOAD->SHIFT on accept. In SHIFT, each cycle moves one entry with a larger low up one slot. When no such entry remains, the new entry is written and the table count increments. The block then goes to LOAD, or to MERGE if the beat carried inLast.
REQ-019 inReady SHALL return high exactly k+1 cycles after an accept, where k is the number of entries shifted.
REQ-020 A beat accepted while the table holds DEPTH entries SHALL be discarded and SHALL set overflow. inLast on that beat SHALL still move the block to MERGE, one cycle after the accept.
REQ-021 MERGE SHALL scan entries 0..count-1, one per cycle, holding curLow and curHigh:
  - if entry.low <= curHigh+1, SHALL set curHigh = max(curHigh, entry.high);
  - otherwise SHALL add curHigh-curLow+1 to the accumulator and start a new run from the entry.
REQ-022 The curHigh+1 comparison SHALL be evaluated at WIDTH+1 bits, so that curHigh = 2^WIDTH-1 does not wrap.
REQ-023 After the last entry, the final run SHALL be added. freshCount SHALL then update, done SHALL pulse for one cycle, and the state SHALL go to DONE. This occurs count+1 cycles after MERGE is entered.
REQ-024 The accumulator SHALL be WIDTH+1 bits, enough to represent the full space 2^WIDTH without overflow.
REQ-025 DONE SHALL hold countValid=1 and freshCount stable, and SHALL ignore inValid, until rst.
REQ-026 freshCount SHALL read 0 and countValid SHALL read 0 in every state other than DONE.

Reset
REQ-027 On rst, the state SHALL be LOAD and these outputs SHALL take their reset values: inReady=1, freshCount=0, done=0, countValid=0, overflow=0.
REQ-028 Also on rst, the table count SHALL be 0, and table contents need not be cleared.
REQ-029 An rst asserted in any state, including mid-SHIFT or mid-MERGE, SHALL abort the job; the partial result SHALL never appear on freshCount.

Configuration
REQ-030 With macro RANGE_UNION_MERGED_COUNT_EN defined, SHALL add port mergedCount  output  ADDR_W+1. The port reports the number of disjoint runs found by MERGE; it is valid with countValid and is 0 otherwise and after reset.
REQ-031 Without RANGE_UNION_MERGED_COUNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Ranges 3-5, 10-14, 16-20, 12-18 (last on 12-18) -> freshCount=14, done pulses once, countValid=1; mergedCount=2 if enabled.
REQ-033 Ranges 1-3, 4-6 (adjacent) -> freshCount=6, mergedCount=1. Range 9-7 alone -> treated as 7-9, freshCount=3.
REQ-034 Descending lows 40-40, 30-30, 20-20, 10-10 -> inReady low for 1, 2, 3, 4 cycles after the respective accepts; freshCount=4.
REQ-035 DEPTH=4 with 6 beats, each 100*i..100*i -> overflow=1 after beat 5; freshCount=4; done fires count+1=5 cycles after MERGE entry.
REQ-036 WIDTH=8, single range 0-255 -> freshCount=256 (9 bits).
REQ-037 WIDTH=8, ranges 0-255 and 10-20 -> freshCount=256, with no wrap in the curHigh+1 comparison.
REQ-038 rst for one cycle in mid-MERGE -> all outputs return to reset values the next cycle. A new job 5-5 then gives freshCount=1.
